led_pattern_ctrl: RTL and testbench

- Stage between the board's raw user inputs (USER_PB[3:0], USER_DIPSW[4:0]) and the LED[7:0] outputs.
- Synchronises and debounces the pushbuttons, and synchronises the DIP switches.
- Runs a pattern engine whose mode and speed are set by the switches and whose run/pause/step/direction/restart are controlled by the buttons.
- Drives the 8 LEDs.

---
 rtl/led_ctrl_pkg.sv | 62 ++++++
 rtl/pb_debounce.sv | 41 ++++
 rtl/led_pattern_ctrl.sv | 107 ++++++++++
 tb/tb_led_pattern_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared mode/state/direction encodings and pattern helpers for the LED pattern engine.
// Pure definitions: no logic, no latency, no flow control.
package led_ctrl_pkg;

  localparam logic [2:0] MODE_OFF       = 3'd0;
  localparam logic [2:0] MODE_BIN       = 3'd1;
  localparam logic [2:0] MODE_RUN_LIGHT = 3'd2;
  localparam logic [2:0] MODE_PINGPONG  = 3'd3;
  localparam logic [2:0] MODE_FILL      = 3'd4;

  typedef enum logic {ST_RUN = 1'b0, ST_PAUSE = 1'b1} state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  localparam logic [7:0] INIT_OFF       = 8'h00;
  localparam logic [7:0] INIT_BIN       = 8'h00;
  localparam logic [7:0] INIT_RUN_LIGHT = 8'h01;
  localparam logic [7:0] INIT_PINGPONG  = 8'h01;
  localparam logic [7:0] INIT_FILL      = 8'h00;

  function automatic logic [7:0] init_pattern(input logic [2:0] mode);
    logic [7:0] p;
    case (mode)
      MODE_BIN:       p = INIT_BIN;
      MODE_RUN_LIGHT: p = INIT_RUN_LIGHT;
      MODE_PINGPONG:  p = INIT_PINGPONG;
      MODE_FILL:      p = INIT_FILL;
      default:        p = INIT_OFF;
    endcase
    return p;
  endfunction

  // Returns {next_dir, next_led}; only ping-pong alters the direction (bounce at the ends).
  function automatic logic [8:0] step_pattern(input logic [2:0] mode, input logic [7:0] led,
                                              input logic dir);
    logic [7:0] nxt;
    logic       nd;
    nxt = 8'h00;
    nd  = dir;
    case (mode)
      MODE_BIN:       nxt = (dir == DIR_FWD) ? led + 8'd1 : led - 8'd1;
      MODE_RUN_LIGHT: nxt = (dir == DIR_FWD) ? {led[6:0], led[7]} : {led[0], led[7:1]};
      MODE_PINGPONG: begin
        if (dir == DIR_FWD) begin
          nxt = {led[6:0], 1'b0};
          if (nxt == 8'h80) nd = DIR_REV;
        end else begin
          nxt = {1'b0, led[7:1]};
          if (nxt == 8'h01) nd = DIR_FWD;
        end
      end
      MODE_FILL: begin
        if (dir == DIR_FWD) nxt = (led == 8'hFF) ? 8'h00 : {led[6:0], 1'b1};
        else                nxt = (led == 8'h00) ? 8'hFF : {1'b0, led[7:1]};
      end
      default:        nxt = 8'h00;
    endcase
    return {nd, nxt};
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// One active-low button: 2-flop sync, stability counter, one-cycle registered press pulse.
// Pulse arrives DB_CYCLES+3 cycles after a settled raw press; no backpressure (free-running).
module pb_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_raw,
  output logic pb_press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;
  logic          level_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync     <= 2'b11;
      cnt      <= '0;
      level    <= 1'b1;
      level_d  <= 1'b1;
      pb_press <= 1'b0;
    end else begin
      sync     <= {sync[0], pb_raw};
      level_d  <= level;
      pb_press <= level_d & ~level;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Button/switch front end plus run/pause pattern engine driving eight LEDs.
// LEDs update one cycle after a step enable or step-button pulse; no backpressure.
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DB_CYCLES   = 1000000,
  parameter int TICK_CYCLES = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] usr_pb,
  input  logic [4:0] usr_dipsw,
  output logic [7:0] led,
  output logic [3:0] pb_pulse,
  output logic       paused
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  for (genvar g = 0; g < 4; g++) begin : g_pb
    pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk      (clk),
      .rst      (rst),
      .pb_raw   (usr_pb[g]),
      .pb_press (pb_pulse[g])
    );
  end

  logic [4:0] dip_s1, dip_s2;
  logic [2:0] mode_s;
  logic [1:0] speed_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dip_s1 <= '1;
      dip_s2 <= '1;
    end else begin
      dip_s1 <= usr_dipsw;
      dip_s2 <= dip_s1;
    end
  end

  assign mode_s  = dip_s2[2:0];
  assign speed_s = dip_s2[4:3];

  logic [TW-1:0] base_cnt;
  logic [1:0]    wrap_cnt;
  logic          base_wrap;
  logic          step_en;

  // >= rather than == so a speed decrease mid-count cannot stall the divider.
  assign base_wrap = (base_cnt == TW'(TICK_CYCLES - 1));
  assign step_en   = base_wrap && (wrap_cnt >= speed_s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_cnt <= '0;
      wrap_cnt <= '0;
    end else begin
      base_cnt <= base_wrap ? '0 : base_cnt + TW'(1);
      if (base_wrap) wrap_cnt <= (wrap_cnt >= speed_s) ? 2'd0 : wrap_cnt + 2'd1;
    end
  end

  state_t     state;
  logic       dir;
  logic [2:0] mode_q;
  logic       dir_t;
  logic       do_step;
  logic [8:0] stepped;

  // Step source depends on the pre-toggle state; a same-cycle PB2 toggle is already applied.
  always_comb begin
    dir_t   = dir ^ pb_pulse[2];
    do_step = (state == ST_RUN) ? step_en : pb_pulse[1];
    stepped = step_pattern(mode_q, led, dir_t);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_RUN;
      dir    <= DIR_FWD;
      mode_q <= MODE_OFF;
      led    <= 8'h00;
      paused <= 1'b0;
    end else begin
      if (pb_pulse[0]) begin
        state  <= (state == ST_RUN) ? ST_PAUSE : ST_RUN;
        paused <= (state == ST_RUN);
      end
      if (mode_s != mode_q) begin
        mode_q <= mode_s;
        led    <= init_pattern(mode_s);
        dir    <= DIR_FWD;
      end else if (pb_pulse[3]) begin
        led <= init_pattern(mode_q);
        dir <= dir_t;
      end else if (do_step) begin
        led <= stepped[7:0];
        dir <= stepped[8];
      end else begin
        dir <= dir_t;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench: expected LED values are queued with each stimulus and popped on every LED change.
module tb_led_pattern_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] usr_pb;
  logic [4:0] usr_dipsw;
  logic [7:0] led;
  logic [3:0] pb_pulse;
  logic       paused;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] sb_q[$];
  bit         sb_armed = 1'b0;
  logic [7:0] prev_led;
  int         last_chg = 0;
  int         gap = 0;
  int         pulse_cnt[4];
  int         pulse_cyc[4];

  always #5 clk = ~clk;

  led_pattern_ctrl #(.DB_CYCLES(4), .TICK_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .usr_pb    (usr_pb),
    .usr_dipsw (usr_dipsw),
    .led       (led),
    .pb_pulse  (pb_pulse),
    .paused    (paused)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Called once per negedge: tracks pulses and scores every LED change while armed.
  task automatic sample();
    logic [7:0] e;
    cyc++;
    if (!rst) begin
      prev_led = led;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (pb_pulse[i]) begin
        pulse_cnt[i]++;
        pulse_cyc[i] = cyc;
      end
    end
    if (led !== prev_led) begin
      if (sb_armed) begin
        if (sb_q.size() == 0) begin
          chk("sb_extra", led, prev_led);
        end else begin
          e = sb_q.pop_front();
          chk("sb_led", led, e);
        end
      end
      gap      = cyc - last_chg;
      last_chg = cyc;
      prev_led = led;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      sample();
    end
  endtask

  task automatic press(input int b);
    usr_pb[b] = 1'b0;
    tick(10);
    usr_pb[b] = 1'b1;
    tick(10);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) tick(1);
    chk("sb_drain", sb_q.size(), 0);
  endtask

  initial begin
    int         base;
    int         t0;
    logic [7:0] hold;
    logic [7:0] v;

    rst       = 1'b0;
    usr_pb    = 4'hF;
    usr_dipsw = 5'd0;
    prev_led  = 8'h00;
    for (int i = 0; i < 4; i++) begin
      pulse_cnt[i] = 0;
      pulse_cyc[i] = 0;
    end
    tick(3);
    chk("rst_led", led, 8'h00);
    chk("rst_paused", paused, 1'b0);
    chk("rst_pulse", pb_pulse, 4'h0);
    rst = 1'b1;
    tick(6);

    // Binary counting at speed 0
    sb_armed = 1'b1;
    sb_q.push_back(8'h01);
    sb_q.push_back(8'h02);
    sb_q.push_back(8'h03);
    usr_dipsw = 5'b00_001;
    drain(60);
    chk("bin_gap", gap, 8);
    chk("bin_paused", paused, 1'b0);
    sb_armed = 1'b0;

    // Short glitch must be rejected, long press pauses
    base = pulse_cnt[0];
    usr_pb[0] = 1'b0;
    tick(3);
    usr_pb[0] = 1'b1;
    tick(10);
    chk("glitch_pulse", pulse_cnt[0] - base, 0);
    chk("glitch_paused", paused, 1'b0);
    t0 = cyc;
    usr_pb[0] = 1'b0;
    tick(20);
    usr_pb[0] = 1'b1;
    tick(10);
    chk("pb0_count", pulse_cnt[0] - base, 1);
    chk("pb0_latency", pulse_cyc[0] - t0, 7);
    chk("pb0_paused", paused, 1'b1);
    hold = led;
    sb_armed = 1'b1;
    tick(40);
    chk("frozen", led, hold);
    sb_armed = 1'b0;

    // Manual stepping in run-light mode
    usr_dipsw = 5'd2;
    tick(6);
    chk("rl_init", led, 8'h01);
    chk("rl_paused", paused, 1'b1);
    sb_armed = 1'b1;
    sb_q.push_back(8'h02);
    press(1);
    drain(20);
    chk("pb1_to_led", last_chg - pulse_cyc[1], 1);
    press(2);
    sb_q.push_back(8'h01);
    press(1);
    drain(20);
    sb_q.push_back(8'h80);
    press(1);
    drain(20);
    sb_armed = 1'b0;

    // Ping-pong with automatic bounce
    usr_dipsw = 5'd3;
    tick(6);
    chk("pp_init", led, 8'h01);
    sb_armed = 1'b1;
    v = 8'h01;
    for (int i = 1; i < 8; i++) begin
      v = {v[6:0], 1'b0};
      sb_q.push_back(v);
    end
    sb_q.push_back(8'h40);
    sb_q.push_back(8'h20);
    press(0);
    drain(150);
    sb_armed = 1'b0;
    chk("pp_running", paused, 1'b0);

    // Fill at speed 1
    press(0);
    chk("fill_pre_paused", paused, 1'b1);
    usr_dipsw = {2'b01, 3'd4};
    tick(6);
    chk("fill_init", led, 8'h00);
    sb_armed = 1'b1;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      v = {v[6:0], 1'b1};
      sb_q.push_back(v);
    end
    sb_q.push_back(8'h00);
    press(0);
    drain(200);
    sb_armed = 1'b0;
    chk("fill_gap", gap, 16);
    press(0);

    // Restart, reverse step and mode switch while paused
    usr_dipsw = 5'd1;
    tick(6);
    chk("bin2_init", led, 8'h00);
    sb_armed = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      sb_q.push_back(8'(i));
      press(1);
    end
    drain(20);
    chk("bin_at5", led, 8'h05);
    sb_q.push_back(8'h00);
    press(3);
    drain(20);
    chk("restart_paused", paused, 1'b1);
    sb_q.push_back(8'hFF);
    press(2);
    press(1);
    drain(20);
    sb_q.push_back(8'h01);
    usr_dipsw = 5'd2;
    tick(6);
    drain(20);
    sb_q.push_back(8'h02);
    press(1);
    drain(20);
    sb_armed = 1'b0;

    // Asynchronous reset mid-count
    press(0);
    usr_dipsw = 5'd1;
    tick(4);
    for (int i = 0; i < 1000 && led !== 8'h37; i++) tick(1);
    chk("reach_37", led, 8'h37);
    #1 rst = 1'b0;
    #1;
    chk("arst_led", led, 8'h00);
    chk("arst_paused", paused, 1'b0);
    chk("arst_pulse", pb_pulse, 4'h0);
    usr_dipsw = 5'd2;
    tick(3);
    rst = 1'b1;
    tick(5);
    chk("post_rst_led", led, 8'h01);
    chk("post_rst_paused", paused, 1'b0);
    chk("sb_final", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
